// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Each access runs IDLE -> ISSUE -> WAIT -> DONE and ends with a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = 2,
  parameter int PRIO_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_fetch,
  output logic              stall_pipe,
  output logic              busy
);

  localparam int   CNT_W     = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  generate
    if (MEM_LAT < 1) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             last_grant;
  logic             is_store;
  logic             pick_data;
  logic             capture;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (if_req || d_req) state_next = ISSUE;
        else                 state_next = IDLE;
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (cnt == CNT_W'(1)) state_next = DONE;
        else                  state_next = WAIT;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant selection and read-capture decode
  always_comb begin
    pick_data = 1'b0;
    if (if_req && d_req) begin
      if (PRIO_DATA != 0) pick_data = 1'b1;
      else                pick_data = (last_grant == OWN_FETCH);
    end else begin
      pick_data = d_req;
    end
    capture = (state == WAIT) && (cnt == CNT_W'(1));
  end

  // Datapath registers; strobes and ready pulses default low every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= {CNT_W{1'b0}};
      owner      <= OWN_FETCH;
      last_grant <= OWN_FETCH;
      is_store   <= 1'b0;
      if_rdata   <= {DATA_W{1'b0}};
      if_ready   <= 1'b0;
      d_rdata    <= {DATA_W{1'b0}};
      d_ready    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= {DATA_W{1'b0}};
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            owner     <= pick_data ? OWN_DATA : OWN_FETCH;
            is_store  <= pick_data & d_we;
            mem_en    <= 1'b1;
            mem_we    <= pick_data & d_we;
            mem_addr  <= pick_data ? d_addr : if_addr;
            mem_wdata <= pick_data ? d_wdata : {DATA_W{1'b0}};
          end
        end
        ISSUE: cnt <= CNT_W'(MEM_LAT);
        WAIT: begin
          if (capture) begin
            if (owner == OWN_DATA) begin
              d_ready <= 1'b1;
              if (!is_store) d_rdata <= mem_rdata;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    last_grant <= owner;
        default: cnt <= {CNT_W{1'b0}};
      endcase
    end
  end

  assign stall_fetch = if_req & ~if_ready;
  assign stall_pipe  = d_req & ~d_ready;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: data-priority instance for latency/priority/store/reset/stall,
// round-robin instance for tie alternation; scoreboards track accesses and responses.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; } acc_t;
  typedef struct { logic is_data; logic [15:0] data; int at; } rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];
  rsp_t rr_q[$];

  logic [15:0] mem [0:255];

  // priority-data instance
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] if_addr = 16'h0000, d_addr = 16'h0000, d_wdata = 16'h0000;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata, pipe1;
  logic        if_ready, d_ready, mem_en, mem_we, stall_fetch, stall_pipe, busy;

  // round-robin instance
  logic        r_if_req = 1'b0, r_d_req = 1'b0;
  logic [15:0] r_if_addr = 16'h0010, r_d_addr = 16'h0020;
  logic [15:0] r_if_rdata, r_d_rdata, r_mem_addr, r_mem_wdata, r_mem_rdata, r_pipe1;
  logic        r_if_ready, r_d_ready, r_mem_en, r_mem_we, r_stall_fetch, r_stall_pipe, r_busy;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .PRIO_DATA(1)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall_fetch(stall_fetch), .stall_pipe(stall_pipe), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .PRIO_DATA(0)) u_rr (
    .clk(clk), .rst(rst),
    .if_req(r_if_req), .if_addr(r_if_addr), .if_rdata(r_if_rdata), .if_ready(r_if_ready),
    .d_req(r_d_req), .d_we(1'b0), .d_addr(r_d_addr), .d_wdata(16'h0000),
    .d_rdata(r_d_rdata), .d_ready(r_d_ready),
    .mem_en(r_mem_en), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
    .mem_rdata(r_mem_rdata),
    .stall_fetch(r_stall_fetch), .stall_pipe(r_stall_pipe), .busy(r_busy)
  );

  // Memory model: data is valid only in the cycle MEM_LAT=2 after the mem_en cycle
  always @(posedge clk) begin
    pipe1       <= mem_en ? mem[mem_addr[7:0]] : 16'h0000;
    mem_rdata   <= pipe1;
    r_pipe1     <= r_mem_en ? mem[r_mem_addr[7:0]] : 16'h0000;
    r_mem_rdata <= r_pipe1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor for the priority-data instance
  always @(negedge clk) begin : mon
    acc_t a;
    rsp_t r;
    if (!rst) begin
      check("mem_we_gated", {31'd0, mem_we & ~mem_en}, 32'd0);
      check("ready_excl", {31'd0, if_ready & d_ready}, 32'd0);
      check("stall_fetch", {31'd0, stall_fetch}, {31'd0, if_req & ~if_ready});
      if (mem_en) begin
        if (acc_q.size() == 0) begin
          check("mem_en_spurious", 32'd1, 32'd0);
        end else begin
          a = acc_q.pop_front();
          check("mem_addr", {16'd0, mem_addr}, {16'd0, a.addr});
          check("mem_we", {31'd0, mem_we}, {31'd0, a.we});
          if (a.we) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, a.wdata});
        end
      end
      if (if_ready || d_ready) begin
        if (rsp_q.size() == 0) begin
          check("ready_spurious", 32'd1, 32'd0);
        end else begin
          r = rsp_q.pop_front();
          check("ready_port", {31'd0, d_ready}, {31'd0, r.is_data});
          check("rdata", {16'd0, (r.is_data ? d_rdata : if_rdata)}, {16'd0, r.data});
          check("ready_cycle", cyc, r.at);
        end
      end
    end
  end

  // Scoreboard monitor for the round-robin instance
  always @(negedge clk) begin : mon_rr
    rsp_t r;
    if (!rst && (r_if_ready || r_d_ready)) begin
      if (rr_q.size() == 0) begin
        check("rr_spurious", 32'd1, 32'd0);
      end else begin
        r = rr_q.pop_front();
        check("rr_port", {31'd0, r_d_ready}, {31'd0, r.is_data});
        check("rr_rdata", {16'd0, (r.is_data ? r_d_rdata : r_if_rdata)}, {16'd0, r.data});
        check("rr_cycle", cyc, r.at);
      end
    end
  end

  task automatic wait_rdy(input bit data_port, input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (data_port ? d_ready : if_ready) got = 1'b1;
    end
    if (!got) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    bit got;
    int seen;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hB1A0;
    mem[8'h20] = 16'h00AA;
    mem[8'h40] = 16'h1234;
    mem[8'h50] = 16'h5555;
    mem[8'h60] = 16'hDEAD;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_outs", {8'd0, if_ready, d_ready, mem_en, mem_we, busy, if_rdata, 7'd0},
          32'd0);
    check("rst_data", {d_rdata, mem_addr}, 32'd0);
    check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single fetch
    if_req = 1'b1; if_addr = 16'h0010;
    acc_q.push_back('{1'b0, 16'h0010, 16'h0000});
    rsp_q.push_back('{1'b0, 16'hB1A0, cyc + 4});
    wait_rdy(1'b0, "t1_timeout");
    if_req = 1'b0;
    @(negedge clk);

    // 2: simultaneous requests, data wins
    if_req = 1'b1; if_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    acc_q.push_back('{1'b0, 16'h0020, 16'h0000});
    acc_q.push_back('{1'b0, 16'h0010, 16'h0000});
    rsp_q.push_back('{1'b1, 16'h00AA, cyc + 4});
    rsp_q.push_back('{1'b0, 16'hB1A0, cyc + 9});
    wait_rdy(1'b1, "t2d_timeout");
    d_req = 1'b0;
    wait_rdy(1'b0, "t2f_timeout");
    if_req = 1'b0;
    @(negedge clk);

    // 3: store keeps d_rdata
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h0006;
    acc_q.push_back('{1'b1, 16'h0030, 16'h0006});
    rsp_q.push_back('{1'b1, 16'h00AA, cyc + 4});
    wait_rdy(1'b1, "t3_timeout");
    d_req = 1'b0; d_we = 1'b0; d_wdata = 16'h0000;
    @(negedge clk);

    // 6: stall_pipe window and address latching
    d_req = 1'b1; d_addr = 16'h0040;
    acc_q.push_back('{1'b0, 16'h0040, 16'h0000});
    rsp_q.push_back('{1'b1, 16'h1234, cyc + 4});
    #1 check("stall_pipe_req", {31'd0, stall_pipe}, 32'd1);
    @(negedge clk);
    d_addr = 16'h0050;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (d_ready) begin
        check("stall_pipe_rdy", {31'd0, stall_pipe}, 32'd0);
        got = 1'b1;
      end else begin
        check("stall_pipe_wait", {31'd0, stall_pipe}, 32'd1);
        check("mem_addr_hold", {16'd0, mem_addr}, 32'h0040);
        @(negedge clk);
      end
    end
    if (!got) check("t6_timeout", 32'd0, 32'd1);
    d_req = 1'b0;
    @(negedge clk);

    // 5: reset in the cycle after mem_en; late 0xDEAD must be dropped
    if_req = 1'b1; if_addr = 16'h0060;
    acc_q.push_back('{1'b0, 16'h0060, 16'h0000});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    check("mid_rst_ctl", {27'd0, if_ready, d_ready, mem_en, mem_we, busy}, 32'd0);
    check("mid_rst_rdata", {if_rdata, d_rdata}, 32'd0);
    check("mid_rst_mem", {mem_addr, mem_wdata}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_rdata", {if_rdata, d_rdata}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("acc_drained", acc_q.size(), 32'd0);
    check("rsp_drained", rsp_q.size(), 32'd0);

    // 4: round-robin with both requests held: D, F, D, F
    r_if_req = 1'b1; r_d_req = 1'b1;
    rr_q.push_back('{1'b1, 16'h00AA, cyc + 4});
    rr_q.push_back('{1'b0, 16'hB1A0, cyc + 9});
    rr_q.push_back('{1'b1, 16'h00AA, cyc + 14});
    rr_q.push_back('{1'b0, 16'hB1A0, cyc + 19});
    seen = 0;
    for (int k = 0; k < 40 && seen < 4; k++) begin
      @(negedge clk);
      if (r_if_ready || r_d_ready) seen++;
    end
    r_if_req = 1'b0; r_d_req = 1'b0;
    check("rr_grants", seen, 32'd4);
    repeat (3) @(negedge clk);
    check("rr_drained", rr_q.size(), 32'd0);
    check("rr_idle", {27'd0, r_busy, r_stall_fetch, r_stall_pipe, r_mem_en, r_mem_we},
          32'd0);
    check("rr_wdata", {16'd0, r_mem_wdata}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
